hazard_ctrl: RTL and testbench

//  Pipeline hazard controller driving the stall/bubble/flush side of the IF/ID and ID/EX pipeline registers.
//  - Detects load-use hazards between the ID-stage instruction and a load in EX; holds PC and IF/ID for

---
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and stall/flush/bubble controls.
// The perf counter width follows CNT_W of the attached hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_RSAddr_In;
    logic [4:0]       ID_RTAddr_In;
    logic             ID_UsesRT_In;
    logic             EX_Mem2RegSEL_In;
    logic             EX_RegWriteEN_In;
    logic [4:0]       EX_WriteAddr_In;
    logic             EX_BranchTaken_In;
    logic             PCWriteEN_Out;
    logic             IFIDWriteEN_Out;
    logic             IFIDFlush_Out;
    logic             IDEXBubble_Out;
    logic [CNT_W-1:0] StallCnt_Out;
    logic [CNT_W-1:0] FlushCnt_Out;

    modport master (
        output ID_RSAddr_In, ID_RTAddr_In, ID_UsesRT_In, EX_Mem2RegSEL_In,
               EX_RegWriteEN_In, EX_WriteAddr_In, EX_BranchTaken_In,
        input  PCWriteEN_Out, IFIDWriteEN_Out, IFIDFlush_Out, IDEXBubble_Out,
               StallCnt_Out, FlushCnt_Out
    );

    modport slave (
        input  ID_RSAddr_In, ID_RTAddr_In, ID_UsesRT_In, EX_Mem2RegSEL_In,
               EX_RegWriteEN_In, EX_WriteAddr_In, EX_BranchTaken_In,
        output PCWriteEN_Out, IFIDWriteEN_Out, IFIDFlush_Out, IDEXBubble_Out,
               StallCnt_Out, FlushCnt_Out
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush controller for the IF/ID and ID/EX registers.
// Optional saturating perf counters are built only when HAZ_PERF_CNT_EN is defined.
//
//  state | meaning
//  RUN   | normal issue; detects load-use hazards and taken branches
//  STALL | holding PC and IF/ID for the remaining load latency cycles
module hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input logic         CLOCK,
    input logic         RESET_N,
    hazard_ctrl_if.slave hif
);
    typedef enum logic {RUN, STALL} state_t;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    state_t     state, state_d;
    logic [2:0] rem, rem_d;
    logic       hazard;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble;

    assign hazard = hif.EX_Mem2RegSEL_In & hif.EX_RegWriteEN_In &
                    (hif.EX_WriteAddr_In != 5'd0) &
                    ((hif.EX_WriteAddr_In == hif.ID_RSAddr_In) |
                     (hif.ID_UsesRT_In & (hif.EX_WriteAddr_In == hif.ID_RTAddr_In)));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            state <= state_d;
            rem   <= rem_d;
        end
    end

    always_comb begin
        state_d     = state;
        rem_d       = rem;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!RESET_N) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hif.EX_BranchTaken_In) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hazard) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_STALL > 1) begin
                            rem_d   = STALL_INIT;
                            state_d = STALL;
                        end
                    end
                end
                STALL: begin
                    // A taken branch here means EX did not hold a bubble; recover by flushing.
                    if (hif.EX_BranchTaken_In) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        rem_d       = 3'd0;
                        state_d     = RUN;
                    end else begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        rem_d       = rem - 3'd1;
                        if (rem == 3'd1) state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 3'd0;
                end
            endcase
        end
    end

    assign hif.PCWriteEN_Out   = pc_we;
    assign hif.IFIDWriteEN_Out = ifid_we;
    assign hif.IFIDFlush_Out   = ifid_flush;
    assign hif.IDEXBubble_Out  = idex_bubble;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hif.StallCnt_Out = stall_cnt;
    assign hif.FlushCnt_Out = flush_cnt;
`else
    assign hif.StallCnt_Out = '0;
    assign hif.FlushCnt_Out = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_STALL 1/3/4, CNT_W 2) on shared stimulus,
// expected outputs queued by a reference model and checked by an independent monitor.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, wa;
    logic       urt, ld, rw, br;

    logic [7:0] act [3];
    logic [23:0] expq [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    int lsv [3] = '{1, 3, 4};
    int sl  [3] = '{0, 0, 0};
    int sc  [3] = '{0, 0, 0};
    int fc  [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl_if #(.CNT_W(2)) hif ();
        assign hif.ID_RSAddr_In      = rs;
        assign hif.ID_RTAddr_In      = rt;
        assign hif.ID_UsesRT_In      = urt;
        assign hif.EX_Mem2RegSEL_In  = ld;
        assign hif.EX_RegWriteEN_In  = rw;
        assign hif.EX_WriteAddr_In   = wa;
        assign hif.EX_BranchTaken_In = br;
        hazard_ctrl #(.LOAD_STALL(g == 0 ? 1 : (g == 1 ? 3 : 4)), .CNT_W(2)) u_dut (
            .CLOCK   (clk),
            .RESET_N (rst_n),
            .hif     (hif.slave)
        );
        assign act[g] = {hif.PCWriteEN_Out, hif.IFIDWriteEN_Out, hif.IFIDFlush_Out,
                         hif.IDEXBubble_Out, hif.StallCnt_Out, hif.FlushCnt_Out};
    end

    // Reference: a hazard costs LOAD_STALL cycles of held PC; sl counts stall cycles still owed.
    task automatic model_push();
        logic [23:0] w;
        logic        hz, pc, ifd, fl, bb;
        logic [1:0]  es, ef;
        w  = '0;
        hz = ld & rw & (wa != 5'd0) & ((wa == rs) | (urt & (wa == rt)));
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                {pc, ifd, fl, bb} = 4'b0011;
                sl[i] = 0; sc[i] = 0; fc[i] = 0;
            end else if (br) begin
                {pc, ifd, fl, bb} = 4'b1111;
                sl[i] = 0;
            end else if (sl[i] > 0) begin
                {pc, ifd, fl, bb} = 4'b0001;
                sl[i] = sl[i] - 1;
            end else if (hz) begin
                {pc, ifd, fl, bb} = 4'b0001;
                sl[i] = lsv[i] - 1;
            end else begin
                {pc, ifd, fl, bb} = 4'b1100;
            end
`ifdef HAZ_PERF_CNT_EN
            es = 2'(sc[i]);
            ef = 2'(fc[i]);
`else
            es = 2'd0;
            ef = 2'd0;
`endif
            if (rst_n) begin
                if (!pc && sc[i] < 3) sc[i] = sc[i] + 1;
                if (fl && fc[i] < 3) fc[i] = fc[i] + 1;
            end
            w[i*8 +: 8] = {pc, ifd, fl, bb, es, ef};
        end
        expq.push_back(w);
    endtask

    task automatic cycle(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic a_urt, input logic a_ld, input logic a_rw,
                         input logic [4:0] a_wa, input logic a_br);
        @(negedge clk);
        rst_n = r; rs = a_rs; rt = a_rt; urt = a_urt;
        ld = a_ld; rw = a_rw; wa = a_wa; br = a_br;
        model_push();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin : monitor
        logic [23:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                w = expq.pop_front();
                cyc_no++;
                for (int i = 0; i < 3; i++) begin
                    n_cmp++;
                    if (act[i] !== w[i*8 +: 8]) begin
                        n_bad++;
                        $display("FAIL outs ls=%0d cycle=%0d pc/ifid/flush/bubble/scnt/fcnt got=%b want=%b",
                                 lsv[i], cyc_no, act[i], w[i*8 +: 8]);
                    end
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; rs = '0; rt = '0; wa = '0; urt = 0; ld = 0; rw = 0; br = 0;
        // Reset with random inputs
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 5'($urandom), 1'($urandom));
        idle(2);
        // Load-use on rs
        cycle(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
        idle(5);
        // Load-use on rt, then same with UsesRT=0
        cycle(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
        idle(5);
        cycle(1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
        idle(2);
        // $zero never hazards; branch beats hazard
        cycle(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
        idle(1);
        cycle(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1);
        idle(2);
        // Reset in the 2nd stall cycle
        cycle(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
        cycle(1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        idle(3);
        // Back-to-back hazards to push stall counters past saturation
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
            idle(3);
        end
        cycle(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
        idle(4);
        // Random traffic with a small register pool so hazards are frequent
        for (int k = 0; k < 3000; k++)
            cycle(($urandom_range(0, 59) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 2) != 0), 1'($urandom),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        idle(2);
        for (int k = 0; k < 20 && expq.size() > 0; k++) @(negedge clk);
        #4;
        n_cmp++;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
